// File: rtl/inst_decode_pkg.sv
// inst_decode_pkg -- shared encodings and the decoded-instruction record for
// the decode stage.
//   op_e        : major opcode field inst[31:30]
//   OP2_*       : op2 sub-opcodes (inst[24:22]) within the branch/SETHI group
//   decoded_t   : everything the decode stage registers for downstream
//   decode_word : pure combinational field extraction of one instruction word
package inst_decode_pkg;

  typedef enum logic [1:0] {
    OP_BR_SETHI = 2'b00,
    OP_CALL     = 2'b01,
    OP_ARITH    = 2'b10,
    OP_MEM      = 2'b11
  } op_e;

  localparam logic [2:0] OP2_SETHI     = 3'b100;
  localparam logic [2:0] OP2_UNIMP     = 3'b000;
  localparam logic [4:0] CALL_LINK_REG = 5'd15;

  // Register fields are kept at the architectural 5-bit format width here; the
  // top resizes them to REG_BITS_SIZE on the way out.
  typedef struct packed {
    op_e         op;
    logic [5:0]  op3;
    logic        i;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        wr_rd;
    logic        illegal;
  } decoded_t;

  function automatic decoded_t decode_word(input logic [31:0] w,
                                           input logic [31:0] pc);
    decoded_t d;
    d       = '0;
    d.op    = op_e'(w[31:30]);
    d.op3   = w[24:19];
    d.i     = w[13];
    d.rd    = w[29:25];
    d.pc    = pc;
    case (d.op)
      OP_BR_SETHI: begin
        d.imm     = {w[21:0], 10'b0};
        d.wr_rd   = (w[24:22] == OP2_SETHI);
        d.illegal = (w[24:22] == OP2_UNIMP);
      end
      OP_CALL: begin
        d.imm   = {w[29:0], 2'b00};
        d.rd    = CALL_LINK_REG;
        d.wr_rd = 1'b1;
      end
      default: begin
        d.rs1   = w[18:14];
        d.rs2   = w[13] ? 5'd0 : w[4:0];
        d.imm   = {{19{w[12]}}, w[12:0]};
        // Arithmetic always writes; memory ops write only for loads (op3[2]=0).
        d.wr_rd = (d.op == OP_ARITH) || !w[21];
      end
    endcase
    // %g0 is hardwired: a write to it is no write at all.
    if (d.rd == 5'd0) d.wr_rd = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/inst_decode_scoreboard.sv
// reg_scoreboard -- busy-register tracker for read-after-write hazards.
//   clk, reset     : clock, synchronous active-high reset (clears all busy)
//   flush          : clears all busy bits, higher priority than set/clear
//   set_en/set_rd  : mark a destination busy (issued instruction)
//   clr_en/clr_rd  : mark a register free (writeback retire)
//   rs1, rs2       : sources of the incoming instruction
//   rs2_en         : rs2 is a real register source (i == 0)
//   hazard         : incoming instruction reads a busy register
module reg_scoreboard
  import inst_decode_pkg::*;
#(
  parameter int REG_BITS_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     set_en,
  input  logic [REG_BITS_SIZE-1:0] set_rd,
  input  logic                     clr_en,
  input  logic [REG_BITS_SIZE-1:0] clr_rd,
  input  logic [REG_BITS_SIZE-1:0] rs1,
  input  logic [REG_BITS_SIZE-1:0] rs2,
  input  logic                     rs2_en,
  output logic                     hazard
);
  localparam int NREG = 2 ** REG_BITS_SIZE;

  logic [NREG-1:0] busy, busy_nxt;

  // Clear is applied before set so a same-cycle retire and reissue of one
  // register leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) busy <= '0;
    else                busy <= busy_nxt;
  end

  assign hazard = busy[rs1] || (rs2_en && busy[rs2]);

endmodule

// File: rtl/inst_decode.sv
// inst_decode -- single registered decode stage with valid/ready handshakes.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : fetched instruction handshake (in_inst, in_pc)
//   out_valid/out_ready  : decoded instruction handshake
//   out_rs1/rs2/rd       : register read addresses and destination
//   out_op/op3/i/imm/pc  : decoded fields, immediate, instruction address
//   out_wr_rd            : instruction writes out_rd
//   out_illegal          : UNIMP encoding seen (still passed downstream)
//   wb_valid/wb_rd       : writeback retire, frees a busy register
//   flush                : kill the held instruction and all busy state
// Build option: DECODE_SCOREBOARD_EN enables the reg_scoreboard hazard
// interlock; without it hazard is 0 and the writeback port is ignored.
module inst_decode
  import inst_decode_pkg::*;
#(
  parameter int REG_BITS_SIZE = 5,
  parameter int INST_SIZE     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_SIZE-1:0]     in_inst,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_BITS_SIZE-1:0] out_rs1,
  output logic [REG_BITS_SIZE-1:0] out_rs2,
  output logic [REG_BITS_SIZE-1:0] out_rd,
  output logic [1:0]               out_op,
  output logic [5:0]               out_op3,
  output logic                     out_i,
  output logic [31:0]              out_imm,
  output logic [31:0]              out_pc,
  output logic                     out_wr_rd,
  output logic                     out_illegal,
  input  logic                     wb_valid,
  input  logic [REG_BITS_SIZE-1:0] wb_rd,
  input  logic                     flush
);

  decoded_t dec, q;
  logic     hazard, accept;

  assign dec = decode_word(32'(in_inst), in_pc);

`ifdef DECODE_SCOREBOARD_EN
  reg_scoreboard #(.REG_BITS_SIZE(REG_BITS_SIZE)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .set_en (accept && dec.wr_rd),
    .set_rd (REG_BITS_SIZE'(dec.rd)),
    .clr_en (wb_valid),
    .clr_rd (wb_rd),
    .rs1    (REG_BITS_SIZE'(dec.rs1)),
    .rs2    (REG_BITS_SIZE'(dec.rs2)),
    .rs2_en (!dec.i),
    .hazard (hazard)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd};
  assign hazard    = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush && !reset;
  assign accept   = in_valid && in_ready;

  // Data registers load only on accept, so they are frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_op      = q.op;
  assign out_op3     = q.op3;
  assign out_i       = q.i;
  assign out_rs1     = REG_BITS_SIZE'(q.rs1);
  assign out_rs2     = REG_BITS_SIZE'(q.rs2);
  assign out_rd      = REG_BITS_SIZE'(q.rd);
  assign out_imm     = q.imm;
  assign out_pc      = q.pc;
  assign out_wr_rd   = q.wr_rd;
  assign out_illegal = q.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode -- randomized scoreboard bench for inst_decode. The monitor
// keeps an ordered queue of expected decoded instructions (at most one is ever
// in flight) and a register busy model when DECODE_SCOREBOARD_EN is defined.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_imm, out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd, wb_rd;
  logic [1:0]  out_op;
  logic [5:0]  out_op3;
  logic        out_i, out_wr_rd, out_illegal, wb_valid, flush;

  inst_decode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_op(out_op), .out_op3(out_op3), .out_i(out_i),
    .out_imm(out_imm), .out_pc(out_pc), .out_wr_rd(out_wr_rd),
    .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned op, op3, i, rs1, rs2, rd, wr, ill;
    logic [31:0] imm, pc;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-format rules.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int unsigned op  = w[31:30];
    int unsigned op2 = w[24:22];
    e.op  = op;
    e.op3 = w[24:19];
    e.i   = w[13];
    e.pc  = pc;
    e.rd  = (op == 1) ? 15 : w[29:25];
    e.rs1 = (op >= 2) ? w[18:14] : 0;
    e.rs2 = (op >= 2 && w[13] == 1'b0) ? w[4:0] : 0;
    if (op == 0)      e.imm = w[21:0] * 1024;
    else if (op == 1) e.imm = w[29:0] * 4;
    else              e.imm = 32'($signed(w[12:0]));
    e.ill = (op == 0 && op2 == 0);
    e.wr  = ((op == 2) || (op == 3 && w[21] == 1'b0) || (op == 0 && op2 == 4) ||
             (op == 1)) && (e.rd != 0);
    return e;
  endfunction

  exp_t exp_q[$];
  bit   busy[32];
  bit   rst_seen = 1'b0;

  // Monitor: checks what the DUT presents now, then advances the model to the
  // state it must hold after the coming rising edge.
  always @(negedge clk) begin
    exp_t cur, f;
    bit   hz, er, acc;
    if (rst_seen) begin
      chk("reset_valid", out_valid, 0);
      chk("reset_data", {out_rs1, out_rs2, out_rd, out_op, out_op3, out_i,
                         out_wr_rd, out_illegal}, 0);
      chk("reset_imm_pc", {out_imm, out_pc}, 0);
    end
    rst_seen = reset;

    cur = ref_decode(in_inst, in_pc);
    hz  = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
    hz = busy[cur.rs1] || (cur.i == 0 && busy[cur.rs2]);
`endif
    er = (exp_q.size() == 0 || out_ready) && !hz && !flush && !reset;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, exp_q.size() != 0);

    if (exp_q.size() != 0 && out_valid) begin
      f = exp_q[0];
      chk("fields", {out_op, out_op3, out_i, out_rs1, out_rs2, out_rd},
          {f.op[1:0], f.op3[5:0], f.i[0], f.rs1[4:0], f.rs2[4:0], f.rd[4:0]});
      chk("imm", out_imm, f.imm);
      chk("pc", out_pc, f.pc);
      chk("wr_ill", {out_wr_rd, out_illegal}, {f.wr[0], f.ill[0]});
    end

    acc = in_valid && er;
    if (reset || flush) begin
      exp_q.delete();
      foreach (busy[k]) busy[k] = 1'b0;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(cur);
      if (wb_valid) busy[wb_rd] = 1'b0;
      if (acc && cur.wr != 0) busy[cur.rd] = 1'b1;
      busy[0] = 1'b0;
    end
  end

  task automatic step(input bit v, input logic [31:0] w, input bit rdy);
    @(posedge clk); #1;
    in_valid  = v;
    in_inst   = w;
    in_pc     = $urandom;
    out_ready = rdy;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    // Keep register fields small so hazards and dependencies actually occur.
    w[29:25] = 5'($urandom_range(0, 7));
    w[18:14] = 5'($urandom_range(0, 7));
    w[4:0]   = 5'($urandom_range(0, 7));
    if (sel == 0)      w[24:22] = 3'b000;
    else if (sel == 1) w[24:22] = 3'b100;
    return w;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed: ADD r3,r1,r2 then ADD r4,r1,-1.
    step(1, 32'h8600_4002, 1);
    step(1, 32'h8800_7FFF, 1);
`ifdef DECODE_SCOREBOARD_EN
    // Retire r3 and r4 so the next directed ops are not held off.
    step(0, 0, 1);
    wb_valid = 1'b1; wb_rd = 5'd3;
    step(0, 0, 1);
    wb_rd = 5'd4;
    step(0, 0, 1);
    wb_valid = 1'b0;
`endif
    // Stall: downstream not ready for three cycles with input pending.
    step(1, 32'h8A00_4002, 1);
    step(1, 32'h8C00_4002, 0);
    step(1, 32'h8C00_4002, 0);
    step(1, 32'h8C00_4002, 0);
    step(1, 32'h8C00_4002, 1);
    step(0, 0, 1);
`ifdef DECODE_SCOREBOARD_EN
    // r3 producer followed by r3 consumer; retire r3 after a few stalls.
    wb_valid = 1'b1; wb_rd = 5'd5;
    step(1, 32'h8600_4002, 1);
    wb_valid = 1'b0;
    step(1, 32'h8800_C001, 1);
    step(1, 32'h8800_C001, 1);
    wb_valid = 1'b1; wb_rd = 5'd3;
    step(1, 32'h8800_C001, 1);
    wb_valid = 1'b0;
    step(0, 0, 1);
    // Same-cycle retire and reissue of r5.
    wb_valid = 1'b1; wb_rd = 5'd5;
    step(1, 32'h8A00_4002, 1);
    wb_valid = 1'b0;
    step(1, 32'h8200_6005, 1);
`endif
    // Flush while holding an output that is not consumed.
    step(1, 32'h8E00_4002, 0);
    step(1, 32'h9000_4002, 0);
    flush = 1'b1;
    step(1, 32'h9000_4002, 0);
    flush = 1'b0;
    step(0, 0, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 3) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 60) == 0);
      reset    = ($urandom_range(0, 150) == 0);
    end
    step(0, 0, 1);
    reset = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 SHALL have parameter REG_BITS_SIZE, default 5, register-specifier width.
REQ-002 SHALL have parameter INST_SIZE, default 32, instruction/data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_inst input INST_SIZE, in_pc input 32: fetched-instruction handshake.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1: decoded-instruction handshake.
REQ-007 SHALL have ports out_rs1, out_rs2, out_rd output REG_BITS_SIZE: register-file read addresses and destination.
REQ-008 SHALL have ports out_op output 2, out_op3 output 6, out_i output 1, out_imm output 32, out_pc output 32, out_wr_rd output 1, out_illegal output 1.
REQ-009 SHALL have ports wb_valid input 1, wb_rd input REG_BITS_SIZE: writeback retire; flush input 1: pipeline kill.

Function
REQ-010 SHALL be a single registered stage: an accepted instruction appears on outputs the next cycle (latency 1).
REQ-011 SHALL accept on in_valid && in_ready; SHALL drive in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-012 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-013 SHALL decode op=inst[31:30], rd=[29:25], op3=[24:19], rs1=[18:14], i=[13], rs2=[4:0].
REQ-014 SHALL form out_imm: op=10/11 -> sign-extended simm13; op=00 -> {imm22,10'b0}; op=01 -> {disp30,2'b00}.
REQ-015 SHALL set out_rs1/out_rs2 to 0 for op=00 and op=01; out_rs2 to 0 when i=1.
REQ-016 SHALL assert out_wr_rd for op=10; op=11 with op3[2]=0 (loads); op=00 with op2=100 (SETHI); op=01 (CALL, out_rd forced to 15); never when destination is 0.
REQ-017 SHALL assert out_illegal for op=00 with op2=000 (UNIMP); instruction still passes with out_wr_rd=0.
REQ-018 SHALL clear out_valid on out_ready when no new instruction is accepted that cycle.
REQ-019 flush SHALL clear out_valid next cycle and block acceptance in the flush cycle; flush has priority over all other events.

Reset
REQ-020 reset SHALL force out_valid=0, all data outputs=0, scoreboard=0 on the next rising edge.
REQ-021 reset mid-handshake SHALL discard the held instruction; in_ready SHALL be 0 while reset is high.

Configuration
REQ-022 With DECODE_SCOREBOARD_EN defined, SHALL keep a 2**REG_BITS_SIZE busy vector; bit 0 always 0.
REQ-023 Scoreboard: accept with out_wr_rd sets busy[rd]; wb_valid clears busy[wb_rd]; set and clear of the same register in one cycle -> set wins.
REQ-024 hazard SHALL be busy[rs1] || (!i && busy[rs2]) for the incoming instruction; flush clears whole vector.
REQ-025 Without DECODE_SCOREBOARD_EN, hazard SHALL be constant 0; wb_valid/wb_rd ignored; no busy storage.

Structure
REQ-026 Shared package SHALL hold the op encodings (OP_CALL, OP_BR_SETHI, OP_ARITH, OP_MEM), the OP2_SETHI/OP2_UNIMP constants and a decoded-instruction struct typedef.
REQ-027 Scoreboard SHALL be a sub-module reg_scoreboard, instantiated only under DECODE_SCOREBOARD_EN.

Verification
REQ-028 ADD r3,r1,r2 (0x86004002) accepted, out_ready=1 -> next cycle out_rs1=1, out_rs2=2, out_rd=3, out_wr_rd=1, out_valid=1.
REQ-029 ADD r4,r1,-1 (0x88007FFF) -> out_i=1, out_imm=0xFFFFFFFF, out_rs2=0.
REQ-030 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, no second instruction lost or duplicated.
REQ-031 Scoreboard on: ADD writing r3, then ADD reading r3 -> in_ready=0 until wb_valid with wb_rd=3; accept the cycle after.
REQ-032 Same-cycle wb_rd=5 and accept of instruction writing r5 -> busy[5] remains 1.
REQ-033 flush while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, scoreboard cleared, input not accepted that cycle.
